// File: rtl/nsr_sweep_bank.sv
// nsr_sweep_bank: per-neuron synaptic current (CUR) and membrane voltage (VOL)
// arrays, global VT/LEAK/VRESET registers, LANES-wide read windows, and an
// in-place leaky-integrate-and-fire sweep engine stepping one neuron per cycle.
module nsr_sweep_bank #(
   parameter int DEPTH  = 32,
   parameter int DATA_W = 32,
   parameter int LANES  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cur_we,
   input  logic [1:0]                cur_vl,
   input  logic [AW-1:0]             cur_wa,
   input  logic [LANES*DATA_W-1:0]   cur_wd,
   input  logic                      vol_we,
   input  logic [AW-1:0]             vol_wa,
   input  logic [DATA_W-1:0]         vol_wd,
   input  logic                      cfg_we,
   input  logic [1:0]                cfg_sel,
   input  logic [DATA_W-1:0]         cfg_wd,
   input  logic [AW-1:0]             ra,
   output logic [LANES*DATA_W-1:0]   cur_out,
   output logic [LANES*DATA_W-1:0]   vol_out,
   output logic [DATA_W-1:0]         rd,
   output logic [DATA_W-1:0]         vt_out,
   input  logic                      start,
   input  logic [AW-1:0]             base,
   input  logic [AW:0]               count,
   output logic                      busy,
   output logic                      done,
   output logic [DEPTH-1:0]          spike_out,
   output logic                      wr_err
);

   // Handshake: start is a level request sampled only while IDLE; busy is
   // high for exactly the cycles in which neurons are stepped; done is a
   // single-cycle completion pulse, after which the engine returns to IDLE.

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [AW:0]               DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic signed [DATA_W-1:0]  SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0]  SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

   state_t                    state;
   logic signed [DATA_W-1:0]  cur_mem [DEPTH];
   logic signed [DATA_W-1:0]  vol_mem [DEPTH];
   logic [AW-1:0]             ptr;
   logic [AW:0]               remaining;
   logic signed [DATA_W-1:0]  vt;
   logic signed [DATA_W-1:0]  leak;
   logic signed [DATA_W-1:0]  vreset;
   logic [DEPTH-1:0]          spike;
   logic                      busy_q;
   logic                      done_q;
   logic                      wr_err_q;

   logic                      idle;
   logic                      cur_wr;
   logic                      vol_wr;
   logic                      cfg_wr;
   logic [LANES-1:0]          lane_en;
   logic [AW:0]               count_clamped;
   logic signed [DATA_W-1:0]  vol_p;
   logic signed [DATA_W-1:0]  cur_p;
   logic signed [DATA_W+1:0]  step_sum;
   logic signed [DATA_W-1:0]  step_v;
   logic                      step_fire;

   assign idle          = (state == IDLE);
   assign cur_wr        = cur_we && (cur_vl != 2'b11);
   assign vol_wr        = vol_we;
   assign cfg_wr        = cfg_we && (cfg_sel != 2'b11);
   assign count_clamped = (count > DEPTH_CNT) ? DEPTH_CNT : count;

   // Lane mask for a vector CUR write: 1, 4 or LANES consecutive entries.
   always_comb begin
      lane_en = '0;
      for (int i = 0; i < LANES; i++) begin
         case (cur_vl)
            2'b00:   lane_en[i] = (i == 0);
            2'b01:   lane_en[i] = (i < 4);
            2'b10:   lane_en[i] = 1'b1;
            default: lane_en[i] = 1'b0;
         endcase
      end
   end

   // LIF step for the neuron under the pointer: widened sum, then saturate.
   // The top three bits of the DATA_W+2 sum agree exactly when it fits.
   always_comb begin
      vol_p    = vol_mem[ptr];
      cur_p    = cur_mem[ptr];
      step_sum = {{2{vol_p[DATA_W-1]}}, vol_p}
               + {{2{cur_p[DATA_W-1]}}, cur_p}
               - {{2{leak[DATA_W-1]}}, leak};
      if (step_sum[DATA_W+1:DATA_W-1] == 3'b000 ||
          step_sum[DATA_W+1:DATA_W-1] == 3'b111) begin
         step_v = step_sum[DATA_W-1:0];
      end else if (step_sum[DATA_W+1]) begin
         step_v = SAT_MIN;
      end else begin
         step_v = SAT_MAX;
      end
      step_fire = (step_v >= vt);
   end

   // CUR array: vector writes from the host while IDLE, wrapping modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < DEPTH; j++) cur_mem[j] <= '0;
      end else if (idle && cur_wr) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) cur_mem[cur_wa + AW'(i)] <= cur_wd[i*DATA_W +: DATA_W];
         end
      end
   end

   // Sweep FSM plus everything it owns: VOL array, config, spikes, status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         vt        <= SAT_MAX;
         leak      <= '0;
         vreset    <= '0;
         spike     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_err_q  <= 1'b0;
         for (int j = 0; j < DEPTH; j++) vol_mem[j] <= '0;
      end else begin
         // Any write attempted outside IDLE is dropped and flagged next cycle.
         wr_err_q <= !idle && (cur_wr || vol_wr || cfg_wr);
         case (state)
            IDLE: begin
               if (vol_wr) vol_mem[vol_wa] <= vol_wd;
               if (cfg_wr) begin
                  case (cfg_sel)
                     2'b00:   vt     <= cfg_wd;
                     2'b01:   leak   <= cfg_wd;
                     2'b10:   vreset <= cfg_wd;
                     default: ;
                  endcase
               end
               if (start) begin
                  ptr       <= base;
                  remaining <= count_clamped;
                  spike     <= '0;
                  if (count_clamped == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (step_fire) begin
                  vol_mem[ptr] <= vreset;
                  spike[ptr]   <= 1'b1;
               end else begin
                  vol_mem[ptr] <= step_v;
               end
               ptr       <= ptr + AW'(1);
               remaining <= remaining - (AW+1)'(1);
               if (remaining == (AW+1)'(1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // Combinational read windows starting at ra, wrapping modulo DEPTH.
   for (genvar g = 0; g < LANES; g++) begin : g_rd
      assign cur_out[g*DATA_W +: DATA_W] = cur_mem[ra + AW'(g)];
      assign vol_out[g*DATA_W +: DATA_W] = vol_mem[ra + AW'(g)];
   end

   assign rd        = cur_mem[ra];
   assign vt_out    = vt;
   assign busy      = busy_q;
   assign done      = done_q;
   assign spike_out = spike;
   assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_nsr_sweep_bank.sv
// Bench for nsr_sweep_bank: directed scenarios from the datasheet plus
// randomized sweeps checked against an array-level LIF model.
module tb_nsr_sweep_bank;

   localparam int DEPTH  = 32;
   localparam int DATA_W = 32;
   localparam int LANES  = 16;
   localparam int AW     = 5;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   // ---------------- clock / reset / DUT ----------------
   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     cur_we;
   logic [1:0]               cur_vl;
   logic [AW-1:0]            cur_wa;
   logic [LANES*DATA_W-1:0]  cur_wd;
   logic                     vol_we;
   logic [AW-1:0]            vol_wa;
   logic [DATA_W-1:0]        vol_wd;
   logic                     cfg_we;
   logic [1:0]               cfg_sel;
   logic [DATA_W-1:0]        cfg_wd;
   logic [AW-1:0]            ra;
   logic [LANES*DATA_W-1:0]  cur_out;
   logic [LANES*DATA_W-1:0]  vol_out;
   logic [DATA_W-1:0]        rd;
   logic [DATA_W-1:0]        vt_out;
   logic                     start;
   logic [AW-1:0]            base;
   logic [AW:0]              count;
   logic                     busy;
   logic                     done;
   logic [DEPTH-1:0]         spike_out;
   logic                     wr_err;

   always #10 clk = ~clk;

   nsr_sweep_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n),
      .cur_we(cur_we), .cur_vl(cur_vl), .cur_wa(cur_wa), .cur_wd(cur_wd),
      .vol_we(vol_we), .vol_wa(vol_wa), .vol_wd(vol_wd),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wd(cfg_wd),
      .ra(ra), .cur_out(cur_out), .vol_out(vol_out), .rd(rd), .vt_out(vt_out),
      .start(start), .base(base), .count(count),
      .busy(busy), .done(done), .spike_out(spike_out), .wr_err(wr_err)
   );

   // ---------------- reference model ----------------
   int               m_cur [DEPTH];
   int               m_vol [DEPTH];
   int               m_vt;
   int               m_leak;
   int               m_vres;
   logic [DEPTH-1:0] m_spk;
   int               checks = 0;
   int               errors = 0;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_cur[i] = 0;
         m_vol[i] = 0;
      end
      m_vt   = int'(MAXV);
      m_leak = 0;
      m_vres = 0;
      m_spk  = '0;
   endtask

   // One LIF sweep over count neurons (clamped to DEPTH) starting at b.
   task automatic model_sweep(input int b, input int c);
      int     n;
      int     p;
      longint s;
      n     = (c > DEPTH) ? DEPTH : c;
      m_spk = '0;
      for (int k = 0; k < n; k++) begin
         p = (b + k) % DEPTH;
         s = longint'(m_vol[p]) + longint'(m_cur[p]) - longint'(m_leak);
         if (s > MAXV) s = MAXV;
         if (s < MINV) s = MINV;
         if (s >= longint'(m_vt)) begin
            m_vol[p] = m_vres;
            m_spk[p] = 1'b1;
         end else begin
            m_vol[p] = int'(s);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cur_we = 0; cur_vl = 2'b11; cur_wa = '0; cur_wd = '0;
      vol_we = 0; vol_wa = '0; vol_wd = '0;
      cfg_we = 0; cfg_sel = 2'b11; cfg_wd = '0;
      ra = '0; start = 0; base = '0; count = '0;
   endtask

   task automatic wr_cur(input logic [1:0] vl, input int wa, input logic [LANES*DATA_W-1:0] wd);
      int len;
      cur_we = 1; cur_vl = vl; cur_wa = AW'(wa); cur_wd = wd;
      tick();
      cur_we = 0; cur_vl = 2'b11;
      len = (vl == 2'b00) ? 1 : (vl == 2'b01) ? 4 : (vl == 2'b10) ? LANES : 0;
      for (int i = 0; i < len; i++) m_cur[(wa + i) % DEPTH] = int'(wd[i*DATA_W +: DATA_W]);
   endtask

   task automatic wr_vol(input int a, input int d);
      vol_we = 1; vol_wa = AW'(a); vol_wd = 32'(d);
      tick();
      vol_we = 0;
      m_vol[a] = d;
   endtask

   task automatic wr_cfg(input logic [1:0] sel, input int d);
      cfg_we = 1; cfg_sel = sel; cfg_wd = 32'(d);
      tick();
      cfg_we = 0; cfg_sel = 2'b11;
      case (sel)
         2'b00:   m_vt = d;
         2'b01:   m_leak = d;
         2'b10:   m_vres = d;
         default: ;
      endcase
   endtask

   // Launch a sweep, measure busy cycles and the cycle (after start edge)
   // carrying done, and return in the first IDLE cycle. done_at = -1 on timeout.
   task automatic run_sweep(input int b, input int c, output int busy_cycles, output int done_at);
      int cyc;
      base = AW'(b); count = (AW+1)'(c); start = 1;
      tick();
      start = 0;
      busy_cycles = 0;
      done_at = -1;
      cyc = 1;
      while (done_at < 0 && cyc <= 80) begin
         if (busy) busy_cycles++;
         if (done) done_at = cyc;
         else begin
            tick();
            cyc++;
         end
      end
      tick();
      model_sweep(b, c);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int w = 0; w < DEPTH; w += LANES) begin
         ra = AW'(w); #1;
         checks++;
         if (cur_out !== '0) begin errors++; $display("FAIL reset_cur_out win %0d: got %h required 0", w, cur_out); end
         checks++;
         if (vol_out !== '0) begin errors++; $display("FAIL reset_vol_out win %0d: got %h required 0", w, vol_out); end
      end
      checks++;
      if (vt_out !== 32'h7FFF_FFFF) begin errors++; $display("FAIL reset_vt: got %h required 7fffffff", vt_out); end
      checks++;
      if ({busy, done, wr_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got busy=%b done=%b wr_err=%b required 0", busy, done, wr_err); end
      checks++;
      if (spike_out !== '0) begin errors++; $display("FAIL reset_spike: got %h required 0", spike_out); end
   endtask

   task automatic test_wrap_write();
      logic [LANES*DATA_W-1:0] wd;
      wd = '0;
      for (int i = 0; i < 4; i++) wd[i*DATA_W +: DATA_W] = 32'(i + 1);
      wd[4*DATA_W +: DATA_W] = 32'd99;   // beyond length 4, must not land
      wr_cur(2'b01, 30, wd);
      ra = AW'(30); #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cur_out[i*DATA_W +: DATA_W] !== 32'(i + 1)) begin
            errors++; $display("FAIL wrap_lane%0d: got %0d required %0d", i, cur_out[i*DATA_W +: DATA_W], i + 1);
         end
      end
      checks++;
      if (cur_out[4*DATA_W +: DATA_W] !== 32'd0) begin errors++; $display("FAIL wrap_len: got %0d required 0", cur_out[4*DATA_W +: DATA_W]); end
      checks++;
      if (rd !== 32'd1) begin errors++; $display("FAIL wrap_rd: got %0d required 1", rd); end
   endtask

   task automatic test_sweep_directed();
      logic [LANES*DATA_W-1:0] wd;
      int bc, da;
      wd = '0;
      for (int i = 0; i < 8; i++) wd[i*DATA_W +: DATA_W] = 32'(i);
      wr_cur(2'b10, 0, wd);
      for (int i = 0; i < 8; i++) wr_vol(i, 5);
      wr_cfg(2'b00, 10);
      wr_cfg(2'b01, 1);
      wr_cfg(2'b10, 0);
      run_sweep(0, 8, bc, da);
      checks++;
      if (bc !== 8) begin errors++; $display("FAIL sweep_busy_cycles: got %0d required 8", bc); end
      checks++;
      if (da !== 9) begin errors++; $display("FAIL sweep_done_cycle: got %0d required 9", da); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL sweep_done_width: got %b required 0", done); end
      checks++;
      if (spike_out !== 32'h0000_00C0) begin errors++; $display("FAIL sweep_spike: got %h required c0", spike_out); end
      ra = '0; #1;
      checks++;
      if (vol_out[3*DATA_W +: DATA_W] !== 32'd7) begin errors++; $display("FAIL sweep_vol3: got %0d required 7", vol_out[3*DATA_W +: DATA_W]); end
      checks++;
      if (vol_out[5*DATA_W +: DATA_W] !== 32'd9) begin errors++; $display("FAIL sweep_vol5: got %0d required 9", vol_out[5*DATA_W +: DATA_W]); end
      checks++;
      if (vol_out[6*DATA_W +: 2*DATA_W] !== 64'd0) begin errors++; $display("FAIL sweep_vol67: got %h required 0", vol_out[6*DATA_W +: 2*DATA_W]); end
      for (int w = 0; w < DEPTH; w += LANES) begin
         ra = AW'(w); #1;
         for (int i = 0; i < LANES; i++) begin
            checks++;
            if (vol_out[i*DATA_W +: DATA_W] !== 32'(m_vol[w + i])) begin
               errors++; $display("FAIL sweep_model_vol[%0d]: got %h required %h", w + i, vol_out[i*DATA_W +: DATA_W], m_vol[w + i]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      logic [LANES*DATA_W-1:0] wd;
      int bc, da;
      wr_vol(0, int'(32'h8000_0010));
      wr_vol(1, int'(32'h7FFF_FFF0));
      wd = '0;
      wd[0 +: DATA_W]      = 32'hFFFF_FF00;
      wd[DATA_W +: DATA_W] = 32'h0000_0100;
      wr_cur(2'b01, 0, wd);
      wr_cfg(2'b01, 0);
      wr_cfg(2'b00, int'(32'h7FFF_FFFF));
      wr_cfg(2'b10, 3);
      run_sweep(0, 2, bc, da);
      ra = '0; #1;
      checks++;
      if (vol_out[0 +: DATA_W] !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg: got %h required 80000000", vol_out[0 +: DATA_W]); end
      checks++;
      if (vol_out[DATA_W +: DATA_W] !== 32'd3) begin errors++; $display("FAIL sat_pos_fire: got %h required 3", vol_out[DATA_W +: DATA_W]); end
      checks++;
      if (spike_out !== 32'h0000_0002) begin errors++; $display("FAIL sat_spike: got %h required 2", spike_out); end
      checks++;
      if (bc !== 2 || da !== 3) begin errors++; $display("FAIL sat_timing: got busy=%0d done_at=%0d required 2/3", bc, da); end
      wr_cfg(2'b00, 10);
      wr_cfg(2'b01, 1);
      wr_cfg(2'b10, 0);
   endtask

   task automatic test_blocked_writes();
      int     wr_err_seen;
      logic   bad_busy;
      wr_vol(10, 77);
      base = AW'(30); count = (AW+1)'(4); start = 1;
      tick();                                   // cycle t+1, RUN
      vol_we = 1; vol_wa = AW'(10); vol_wd = 32'd123;
      cfg_we = 1; cfg_sel = 2'b00; cfg_wd = 32'd0;
      base = AW'(5); count = (AW+1)'(3);        // start stays high: must be ignored
      tick();                                   // cycle t+2
      vol_we = 0; cfg_we = 0; cfg_sel = 2'b11; start = 0;
      checks++;
      if (wr_err !== 1'b1) begin errors++; $display("FAIL blocked_wr_err_pulse: got %b required 1", wr_err); end
      wr_err_seen = 0;
      bad_busy = 1'b0;
      for (int c = 3; c <= 4; c++) begin
         tick();
         if (wr_err) wr_err_seen++;
         if (!busy || done) bad_busy = 1'b1;
      end
      checks++;
      if (wr_err_seen !== 0) begin errors++; $display("FAIL blocked_wr_err_once: got %0d extra pulses required 0", wr_err_seen); end
      checks++;
      if (bad_busy !== 1'b0) begin errors++; $display("FAIL blocked_busy: busy/done wrong in cycles t+3..t+4"); end
      tick();                                   // cycle t+5
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL blocked_done: got %b required 1", done); end
      tick();                                   // t+6 IDLE; restarted sweep would show busy
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL blocked_restart: got busy=%b done=%b required 0", busy, done); end
      model_sweep(30, 4);
      checks++;
      if (vt_out !== 32'd10) begin errors++; $display("FAIL blocked_cfg: got %0d required 10", vt_out); end
      checks++;
      if (spike_out !== m_spk) begin errors++; $display("FAIL blocked_spike: got %h required %h", spike_out, m_spk); end
      for (int w = 0; w < DEPTH; w += LANES) begin
         ra = AW'(w); #1;
         for (int i = 0; i < LANES; i++) begin
            checks++;
            if (vol_out[i*DATA_W +: DATA_W] !== 32'(m_vol[w + i])) begin
               errors++; $display("FAIL blocked_vol[%0d]: got %h required %h", w + i, vol_out[i*DATA_W +: DATA_W], m_vol[w + i]);
            end
         end
      end
   endtask

   task automatic test_count_edges();
      int bc, da;
      run_sweep(7, 0, bc, da);
      checks++;
      if (bc !== 0 || da !== 1) begin errors++; $display("FAIL count0_timing: got busy=%0d done_at=%0d required 0/1", bc, da); end
      checks++;
      if (spike_out !== '0) begin errors++; $display("FAIL count0_spike: got %h required 0", spike_out); end
      run_sweep(9, 40, bc, da);
      checks++;
      if (bc !== 32 || da !== 33) begin errors++; $display("FAIL clamp_timing: got busy=%0d done_at=%0d required 32/33", bc, da); end
      checks++;
      if (spike_out !== m_spk) begin errors++; $display("FAIL clamp_spike: got %h required %h", spike_out, m_spk); end
   endtask

   task automatic test_back_to_back();
      int bc, da;
      run_sweep(12, 3, bc, da);
      run_sweep(20, 5, bc, da);
      checks++;
      if (bc !== 5 || da !== 6) begin errors++; $display("FAIL b2b_timing: got busy=%0d done_at=%0d required 5/6", bc, da); end
      checks++;
      if (spike_out !== m_spk) begin errors++; $display("FAIL b2b_spike: got %h required %h", spike_out, m_spk); end
   endtask

   task automatic test_random();
      logic [LANES*DATA_W-1:0] wd;
      int bc, da, b, c, n;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < LANES; i++) begin
            if (it == 5) wd[i*DATA_W +: DATA_W] = $urandom;
            else         wd[i*DATA_W +: DATA_W] = 32'(int'($urandom_range(0, 20)) - 8);
         end
         wr_cur(2'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH - 1)), wd);
         for (int k = 0; k < 4; k++) begin
            if (it == 6) wr_vol(int'($urandom_range(0, DEPTH - 1)), int'($urandom));
            else         wr_vol(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 30)) - 10);
         end
         wr_cfg(2'b00, int'($urandom_range(0, 50)) - 10);
         wr_cfg(2'b01, int'($urandom_range(0, 4)));
         wr_cfg(2'b10, int'($urandom_range(0, 16)) - 8);
         b = int'($urandom_range(0, DEPTH - 1));
         c = int'($urandom_range(0, 40));
         n = (c > DEPTH) ? DEPTH : c;
         run_sweep(b, c, bc, da);
         checks++;
         if (bc !== n || da !== n + 1) begin errors++; $display("FAIL rand%0d_timing: got busy=%0d done_at=%0d required %0d/%0d", it, bc, da, n, n + 1); end
         checks++;
         if (spike_out !== m_spk) begin errors++; $display("FAIL rand%0d_spike: got %h required %h", it, spike_out, m_spk); end
         checks++;
         if (wr_err !== 1'b0) begin errors++; $display("FAIL rand%0d_wr_err: got %b required 0", it, wr_err); end
         for (int w = 0; w < DEPTH; w += LANES) begin
            ra = AW'(w); #1;
            for (int i = 0; i < LANES; i++) begin
               checks++;
               if (vol_out[i*DATA_W +: DATA_W] !== 32'(m_vol[w + i]) ||
                   cur_out[i*DATA_W +: DATA_W] !== 32'(m_cur[w + i])) begin
                  errors++; $display("FAIL rand%0d_entry[%0d]: got vol=%h cur=%h required vol=%h cur=%h", it, w + i,
                     vol_out[i*DATA_W +: DATA_W], cur_out[i*DATA_W +: DATA_W], m_vol[w + i], m_cur[w + i]);
               end
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int done_seen;
      base = '0; count = (AW+1)'(8); start = 1;
      tick();
      start = 0;
      tick();
      tick();                                   // step 2 in progress
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b required 1", busy); end
      rst_n = 0;
      #1;
      model_reset();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || spike_out !== '0) begin
         errors++; $display("FAIL midrst_status: got busy=%b done=%b spike=%h required 0", busy, done, spike_out);
      end
      checks++;
      if (vt_out !== 32'h7FFF_FFFF) begin errors++; $display("FAIL midrst_vt: got %h required 7fffffff", vt_out); end
      for (int w = 0; w < DEPTH; w += LANES) begin
         ra = AW'(w); #1;
         checks++;
         if (cur_out !== '0 || vol_out !== '0) begin errors++; $display("FAIL midrst_arrays win %0d: got cur=%h vol=%h required 0", w, cur_out, vol_out); end
      end
      rst_n = 1;
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done || busy) done_seen++;
      end
      checks++;
      if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d busy/done cycles required 0", done_seen); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      model_reset();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
      test_reset();
      test_wrap_write();
      test_sweep_directed();
      test_saturation();
      test_blocked_writes();
      test_count_edges();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
